// File: rtl/cpu6_ifetch_if.sv
// cpu6_ifetch_if: instruction-memory request/ack bus between the fetch unit and memory
interface cpu6_ifetch_if;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_ack;
    logic [31:0] ifu_rdata;

    modport master (output ifu_req, output ifu_addr, input ifu_ack, input ifu_rdata);
    modport slave  (input ifu_req, input ifu_addr, output ifu_ack, output ifu_rdata);
endinterface

// File: rtl/cpu6_ifetch.sv
// cpu6_ifetch: fetch stage issuing one request at a time, with stall and execute-stage redirects
module cpu6_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  stallF,
    input  logic                  pcsrcE,
    input  logic [31:0]           branchtargetE,
    cpu6_ifetch_if.master         bus,
    output logic [31:0]           instrD,
    output logic [31:0]           pcD,
    output logic                  validD
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic        valid_q, valid_d;
    logic [31:0] redirect;

    assign redirect      = {branchtargetE[31:2], 2'b00};
    assign bus.ifu_req   = (state_q == REQ);
    assign bus.ifu_addr  = pc_q;
    assign instrD        = instr_q;
    assign pcD           = pcd_q;
    assign validD        = valid_q;

    // next state: a redirect always beats a stall; an in-flight request is never altered, only marked killed
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d    = pcsrcE ? redirect : pc_q;
                state_d = (pcsrcE || !stallF) ? REQ : HOLD;
            end
            REQ: begin
                if (bus.ifu_ack) begin
                    if (kill_q || pcsrcE) begin
                        pc_d   = pcsrcE ? redirect : tgt_q;
                        kill_d = 1'b0;
                    end else begin
                        instr_d = bus.ifu_rdata;
                        pcd_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = stallF ? HOLD : REQ;
                    end
                end else if (pcsrcE) begin
                    kill_d = 1'b1;
                    tgt_d  = redirect;
                end
            end
            HOLD: begin
                pc_d    = pcsrcE ? redirect : pc_q;
                state_d = (pcsrcE || !stallF) ? REQ : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            tgt_q   <= 32'h0;
            instr_q <= 32'h0;
            pcd_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_cpu6_ifetch.sv
// tb_cpu6_ifetch: directed checks of fetch sequencing, stalls, redirects, wrap and reset
module tb_cpu6_ifetch;
    localparam logic [31:0] K = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stallF = 1'b0;
    logic        pcsrcE = 1'b0;
    logic [31:0] branchtargetE = 32'h0;
    logic [31:0] instrD, pcD;
    logic        validD;
    logic [97:0] exp_v;
    int          vectors = 0;
    int          miscompares = 0;

    cpu6_ifetch_if bus();

    cpu6_ifetch #(.RESET_PC(32'h0)) dut (
        .clk(clk), .resetn(resetn), .stallF(stallF), .pcsrcE(pcsrcE),
        .branchtargetE(branchtargetE), .bus(bus),
        .instrD(instrD), .pcD(pcD), .validD(validD)
    );

    // zero-wait memory model: the word is a fixed scramble of its address
    assign bus.ifu_rdata = bus.ifu_addr ^ K;

    wire [97:0] obs = {bus.ifu_req, bus.ifu_addr, validD, pcD, instrD};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; bus.ifu_ack = 1'b1;
        step(); step();
        exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL reset: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        resetn = 1'b1;
        step();
        exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL stream_idle: got %h want %h", obs, exp_v); end
        for (int i = 1; i <= 3; i++) begin
            step();
            a = 32'(i * 4);
            exp_v = {1'b1, a, 1'b1, a - 32'd4, (a - 32'd4) ^ K};
            vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL stream_%0d: got %h want %h", i, obs, exp_v); end
        end
    endtask

    task automatic test_stall();
        step();
        exp_v = {1'b1, 32'h10, 1'b1, 32'hC, 32'hC ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL stall_pre: got %h want %h", obs, exp_v); end
        stallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {1'b0, 32'h14, (i == 0), 32'h10, 32'h10 ^ K};
            vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp_v); end
        end
        stallF = 1'b0;
        step();
        exp_v = {1'b1, 32'h14, 1'b0, 32'h10, 32'h10 ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL stall_resume: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_kill();
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {1'b1, 32'h18 + 32'(i * 4), 1'b1, 32'h14 + 32'(i * 4), (32'h14 + 32'(i * 4)) ^ K};
            vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL kill_pre_%0d: got %h want %h", i, obs, exp_v); end
        end
        bus.ifu_ack = 1'b0; pcsrcE = 1'b1; branchtargetE = 32'h103;
        step();
        pcsrcE = 1'b0; branchtargetE = 32'h0;
        exp_v = {1'b1, 32'h20, 1'b0, 32'h1C, 32'h1C ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL kill_wait1: got %h want %h", obs, exp_v); end
        step();
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL kill_wait2: got %h want %h", obs, exp_v); end
        bus.ifu_ack = 1'b1;
        step();
        exp_v = {1'b1, 32'h100, 1'b0, 32'h1C, 32'h1C ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL kill_discard: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_redirect_ack();
        pcsrcE = 1'b1; branchtargetE = 32'h200; stallF = 1'b1;
        step();
        pcsrcE = 1'b0; stallF = 1'b0;
        exp_v = {1'b1, 32'h200, 1'b0, 32'h1C, 32'h1C ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL redirect_ack: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_last_wins();
        bus.ifu_ack = 1'b0; pcsrcE = 1'b1; branchtargetE = 32'h300;
        step();
        exp_v = {1'b1, 32'h200, 1'b0, 32'h1C, 32'h1C ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL last_wins_1: got %h want %h", obs, exp_v); end
        branchtargetE = 32'h403;
        step();
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL last_wins_2: got %h want %h", obs, exp_v); end
        pcsrcE = 1'b0; bus.ifu_ack = 1'b1;
        step();
        exp_v = {1'b1, 32'h400, 1'b0, 32'h1C, 32'h1C ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL last_wins_pc: got %h want %h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h404, 1'b1, 32'h400, 32'h400 ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL last_wins_fetch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_hold_redirect();
        stallF = 1'b1;
        step();
        exp_v = {1'b0, 32'h408, 1'b1, 32'h404, 32'h404 ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL hold_enter: got %h want %h", obs, exp_v); end
        pcsrcE = 1'b1; branchtargetE = 32'h7FE;
        step();
        pcsrcE = 1'b0; stallF = 1'b0;
        exp_v = {1'b1, 32'h7FC, 1'b0, 32'h404, 32'h404 ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL hold_redirect: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_wrap();
        pcsrcE = 1'b1; branchtargetE = 32'hFFFF_FFFF;
        step();
        pcsrcE = 1'b0;
        exp_v = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h404, 32'h404 ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL wrap_setup: got %h want %h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL wrap: got %h want %h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h4, 1'b1, 32'h0, K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL wrap_next: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        bus.ifu_ack = 1'b0;
        step();
        exp_v = {1'b1, 32'h4, 1'b0, 32'h0, K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL mid_wait: got %h want %h", obs, exp_v); end
        resetn = 1'b0; bus.ifu_ack = 1'b1;
        step();
        exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL mid_reset: got %h want %h", obs, exp_v); end
        resetn = 1'b1;
        step();
        exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL mid_idle_ack: got %h want %h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h4, 1'b1, 32'h0, K};
        vectors++; if (obs !== exp_v) begin miscompares++; $display("FAIL mid_restart: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        bus.ifu_ack = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_kill();
        test_redirect_ack();
        test_last_wins();
        test_hold_redirect();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu6_ifetch.md
CPU6_IFETCH -- requirements
Module: cpu6_ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the first fetch address after reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 resetn  in  1  SHALL be the synchronous, active-low reset.
REQ-004 stallF  in  1  SHALL be the hazard-control stall; it blocks issue of new fetches.
REQ-005 pcsrcE  in  1  SHALL be the execute-stage redirect strobe (branch taken / jump).
REQ-006 branchtargetE  in  32  SHALL be the redirect target, valid when pcsrcE=1.
REQ-007 ifu_req  out  1  SHALL be the instruction-memory request valid.
REQ-008 ifu_addr  out  32  SHALL be the request address.
REQ-009 ifu_ack  in  1  SHALL complete the request in the cycle it is sampled high with ifu_req=1.
REQ-010 ifu_rdata  in  32  SHALL be the instruction word, valid with ifu_ack.
REQ-011 instrD  out  32  SHALL be the registered instruction to decode.
REQ-012 pcD  out  32  SHALL be the registered PC of instrD.
REQ-013 validD  out  1  SHALL mark instrD/pcD valid for exactly that cycle.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ and HOLD; ifu_req SHALL equal (state==REQ), and ifu_addr SHALL equal the pc register.
REQ-015 IDLE SHALL last one cycle after reset release, then go to REQ if stallF=0, else to HOLD.
REQ-016 In REQ, ifu_req and ifu_addr SHALL remain stable until ifu_ack; the address SHALL never change mid-request.
REQ-017 If REQ receives an ack with no pending kill and pcsrcE=0, the block SHALL register ifu_rdata into instrD and pc into pcD, and SHALL set validD=1 in the next cycle.
REQ-018 On that ack, pc SHALL become pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-019 After that ack, the next state SHALL be REQ if stallF=0 (back-to-back, one instruction per cycle with zero-wait memory), else HOLD.
REQ-020 HOLD SHALL issue no request, and SHALL go to REQ in the first cycle with stallF=0 or pcsrcE=1.
REQ-021 pcsrcE=1 in HOLD or IDLE SHALL load pc with {branchtargetE[31:2],2'b00}.
REQ-022 pcsrcE=1 in REQ with ifu_ack=1 SHALL discard ifu_rdata (validD=0 next cycle), load pc with the target, and stay in REQ.
REQ-023 pcsrcE=1 in REQ with ifu_ack=0 SHALL set the kill flag and latch the aligned target; the pending request SHALL remain unchanged.
REQ-024 The ack that ends a killed request SHALL be discarded, SHALL load pc from the latched target, SHALL clear the kill flag, and the FSM SHALL stay in REQ.
REQ-025 A second pcsrcE while kill is set SHALL overwrite the latched target (last redirect wins).
REQ-026 pcsrcE SHALL take priority over stallF in every state.
REQ-027 validD SHALL be 0 in every cycle not directly following an accepted (non-discarded) ack; instrD/pcD SHALL hold their last values when validD=0.
REQ-028 ifu_ack while ifu_req=0 SHALL be ignored.

Reset
REQ-029 resetn=0 on an edge SHALL force: state=IDLE, pc=RESET_PC, kill=0, latched target=0, ifu_req=0, validD=0, instrD=0, pcD=0.
REQ-030 Reset mid-request SHALL abandon the request; an ack arriving after reset (before the new REQ) SHALL be ignored.

Verification
REQ-031 Reset release, ack tied 1, stallF=0 -> ifu_addr 0x0,0x4,0x8 on consecutive cycles; validD=1 each cycle from cycle 2 with pcD trailing by one.
REQ-032 stallF=1 for 3 cycles after ack at 0x10 -> HOLD, ifu_req=0 for 3 cycles, next request at 0x14.
REQ-033 Request at 0x20 with ack delayed 2 cycles, pcsrcE=1 target 0x103 in first wait cycle -> addr stays 0x20, data discarded (validD=0), next ifu_addr=0x100.
REQ-034 pcsrcE=1 target 0x200 coincident with ack and stallF=1 -> data discarded, next ifu_addr=0x200 with ifu_req=1.
REQ-035 pc=0xFFFF_FFFC acked -> next ifu_addr=0x0000_0000; resetn=0 mid-request -> ifu_req=0 next cycle, pc=RESET_PC, validD=0.
